pixel_frame_buffer: RTL and testbench

- Producer end of the controller's pixel interface (write_en / data_ready / pixel_data1 / pixel_data2 / shift_network).
- Accepts one 12x12 frame of 4-bit pixels from the host as 72 packed bytes, holding write_en high while it loads.
- Once loaded, it presents a circular byte window to the network controller and rotates it on each shift_network pulse.
- It releases the frame on network_done.

---
 rtl/pixel_pkg.sv | 20 ++
 rtl/pixel_frame_buffer_ring_ptr.sv | 35 +++
 rtl/pixel_frame_buffer.sv | 179 +++++++++++++++++
 tb/tb_pixel_frame_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel frame buffer.
// A frame is 12x12 pixels of PIXEL_W bits, packed two pixels per byte.
package pixel_pkg;

  localparam int FRAME_BYTES = 72;
  localparam int PIXEL_W     = 4;

  typedef enum logic [1:0] {
    PB_IDLE = 2'd0,
    PB_LOAD = 2'd1,
    PB_RUN  = 2'd2
  } pb_state_t;

  // One buffer entry: pixel 2k+1 in the high nibble, pixel 2k in the low nibble.
  typedef struct packed {
    logic [PIXEL_W-1:0] hi;
    logic [PIXEL_W-1:0] lo;
  } pix_pair_t;

endpackage

// File: rtl/pixel_frame_buffer_ring_ptr.sv
// Wrapping pointer counter: counts 0..NUM-1 and wraps to 0.
// clr has priority over inc so a clear and an advance in the same cycle yield 0.
module ring_ptr #(
  parameter int NUM = 72,
  parameter int W   = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  localparam logic [W-1:0] LAST_IDX = W'(NUM - 1);
  localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] ZERO     = {W{1'b0}};

  logic [W-1:0] ptr_r;

  // Pointer register: reset/clear to zero, otherwise advance with wrap on inc.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= ZERO;
    end else if (clr) begin
      ptr_r <= ZERO;
    end else if (inc) begin
      ptr_r <= (ptr_r == LAST_IDX) ? ZERO : (ptr_r + ONE);
    end else begin
      ptr_r <= ptr_r;
    end
  end

  assign ptr = ptr_r;

endmodule

// File: rtl/pixel_frame_buffer.sv
// Pixel frame buffer: loads one 72-byte frame from the host, then presents a
// rotating two-byte window to the network controller until network_done.
// Optional rotation check enabled by defining PIXEL_FRAME_BUFFER_ROTCHK_EN,
// which adds the sticky rot_err output.
module pixel_frame_buffer
  import pixel_pkg::*;
#(
  parameter int NUM_BYTES = FRAME_BYTES,
  parameter int PTR_W     = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic [7:0] pix_byte,
  output logic       pix_ready,
  input  logic       data_ready,
  input  logic       network_done,
  input  logic       shift_network,
  output logic       write_en,
  output logic [7:0] pixel_data1,
  output logic [7:0] pixel_data2,
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
  output logic       rot_err,
`endif
  output logic       frame_busy
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_BYTES - 1);
  localparam logic [PTR_W-1:0] ONE      = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] ZERO     = {PTR_W{1'b0}};

  pb_state_t          state_r;
  logic               write_en_r;
  logic               frame_busy_r;
  pix_pair_t          buf_r [NUM_BYTES];

  logic               pix_ready_s;
  logic               accept_s;
  logic               in_run_s;
  logic               rd_inc_s;
  logic               rd_clr_s;
  logic [PTR_W-1:0]   wr_ptr_s;
  logic [PTR_W-1:0]   rd_ptr_s;
  logic [PTR_W-1:0]   rd_nxt_s;

  // Host handshake: new frames only when idle and the controller is ready;
  // during a load every offered byte is taken; nothing is taken while running.
  always_comb begin
    pix_ready_s = 1'b0;
    case (state_r)
      PB_IDLE: pix_ready_s = data_ready;
      PB_LOAD: pix_ready_s = 1'b1;
      PB_RUN:  pix_ready_s = 1'b0;
      default: pix_ready_s = 1'b0;
    endcase
  end

  assign accept_s = pix_valid && pix_ready_s;
  assign in_run_s = (state_r == PB_RUN);
  // network_done beats shift_network because clear has priority in ring_ptr.
  assign rd_clr_s = in_run_s && network_done;
  assign rd_inc_s = in_run_s && shift_network;

  // Write pointer sits at 0 in IDLE, so the first byte lands in entry 0 and
  // the 72nd accept wraps it back to 0 ready for the next frame.
  ring_ptr #(.NUM(NUM_BYTES), .W(PTR_W)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (accept_s),
    .ptr (wr_ptr_s)
  );

  ring_ptr #(.NUM(NUM_BYTES), .W(PTR_W)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (rd_clr_s),
    .inc (rd_inc_s),
    .ptr (rd_ptr_s)
  );

  // Frame sequencing and the registered write_en / frame_busy flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= PB_IDLE;
      write_en_r   <= 1'b0;
      frame_busy_r <= 1'b0;
    end else begin
      case (state_r)
        PB_IDLE: begin
          if (accept_s) begin
            state_r      <= PB_LOAD;
            write_en_r   <= 1'b1;
            frame_busy_r <= 1'b1;
          end else begin
            state_r      <= PB_IDLE;
            write_en_r   <= 1'b0;
            frame_busy_r <= frame_busy_r;
          end
        end
        PB_LOAD: begin
          if (accept_s && (wr_ptr_s == LAST_IDX)) begin
            state_r    <= PB_RUN;
            write_en_r <= 1'b0;
          end else begin
            state_r    <= PB_LOAD;
            write_en_r <= 1'b1;
          end
          frame_busy_r <= 1'b1;
        end
        PB_RUN: begin
          if (network_done) begin
            state_r      <= PB_IDLE;
            frame_busy_r <= 1'b0;
          end else begin
            state_r      <= PB_RUN;
            frame_busy_r <= 1'b1;
          end
          write_en_r <= 1'b0;
        end
        default: begin
          state_r      <= PB_IDLE;
          write_en_r   <= 1'b0;
          frame_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Frame storage: cleared on reset so the window reads zero, written on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        buf_r[i] <= '{hi: {PIXEL_W{1'b0}}, lo: {PIXEL_W{1'b0}}};
      end
    end else if (accept_s) begin
      buf_r[wr_ptr_s] <= pix_pair_t'(pix_byte);
    end else begin
      buf_r <= buf_r;
    end
  end

  // Second window byte wraps from the last entry back to entry 0.
  always_comb begin
    rd_nxt_s = ZERO;
    if (rd_ptr_s == LAST_IDX) begin
      rd_nxt_s = ZERO;
    end else begin
      rd_nxt_s = rd_ptr_s + ONE;
    end
  end

`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
  logic rot_err_r;

  // Sticky flag: frame released with the window not back at entry 0; a new
  // frame's first byte clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rot_err_r <= 1'b0;
    end else if ((state_r == PB_IDLE) && accept_s) begin
      rot_err_r <= 1'b0;
    end else if (rd_clr_s && (rd_ptr_s != ZERO)) begin
      rot_err_r <= 1'b1;
    end else begin
      rot_err_r <= rot_err_r;
    end
  end

  assign rot_err = rot_err_r;
`endif

  assign pix_ready   = pix_ready_s;
  assign write_en    = write_en_r;
  assign frame_busy  = frame_busy_r;
  assign pixel_data1 = buf_r[rd_ptr_s];
  assign pixel_data2 = buf_r[rd_nxt_s];

endmodule

// File: tb/tb_pixel_frame_buffer.sv
// Directed self-checking bench for pixel_frame_buffer.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_pixel_frame_buffer;

  logic       clk;
  logic       rst;
  logic       pix_valid;
  logic [7:0] pix_byte;
  logic       pix_ready;
  logic       data_ready;
  logic       network_done;
  logic       shift_network;
  logic       write_en;
  logic [7:0] pixel_data1;
  logic [7:0] pixel_data2;
  logic       frame_busy;
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
  logic       rot_err;
`endif

  int tests;
  int fails;
  int we_cnt;

  pixel_frame_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .pix_valid     (pix_valid),
    .pix_byte      (pix_byte),
    .pix_ready     (pix_ready),
    .data_ready    (data_ready),
    .network_done  (network_done),
    .shift_network (shift_network),
    .write_en      (write_en),
    .pixel_data1   (pixel_data1),
    .pixel_data2   (pixel_data2),
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
    .rot_err       (rot_err),
`endif
    .frame_busy    (frame_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Stream 72 bytes base+k; optionally insert a one-cycle host gap after
  // every accept where k % gap_mod == 2, checking write_en holds high.
  task automatic load_frame(input logic [7:0] base, input int gap_mod);
    for (int k = 0; k < 72; k++) begin
      pix_valid = 1'b1;
      pix_byte  = 8'(base + 8'(k));
      tick();
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
      if (k == 0) check("rot_err_clr_first_byte", {31'd0, rot_err}, 32'd0);
`endif
      if ((gap_mod > 0) && ((k % gap_mod) == 2) && (k < 71)) begin
        pix_valid = 1'b0;
        pix_byte  = 8'hFF;
        tick();
        check("gap_write_en", {31'd0, write_en}, 32'd1);
      end
    end
    pix_valid = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0; we_cnt = 0;
    rst = 1'b1; pix_valid = 1'b0; pix_byte = 8'h00; data_ready = 1'b0;
    network_done = 1'b0; shift_network = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_write_en",   {31'd0, write_en},   32'd0);
    check("rst_frame_busy", {31'd0, frame_busy}, 32'd0);
    check("rst_pd1",        {24'd0, pixel_data1}, 32'h00);
    check("rst_pd2",        {24'd0, pixel_data2}, 32'h00);
    check("rst_pix_ready",  {31'd0, pix_ready},  32'd0);
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
    check("rst_rot_err",    {31'd0, rot_err},    32'd0);
`endif

    // Backpressure: controller not ready, host offers a byte
    pix_valid = 1'b1; pix_byte = 8'hAA;
    #1;
    check("bp_pix_ready", {31'd0, pix_ready}, 32'd0);
    tick(); tick();
    check("bp_write_en",   {31'd0, write_en},   32'd0);
    check("bp_frame_busy", {31'd0, frame_busy}, 32'd0);
    check("bp_pd1",        {24'd0, pixel_data1}, 32'h00);

    // Basic load 0x00..0x47 back to back
    data_ready = 1'b1; pix_valid = 1'b0;
    #1;
    check("idle_pix_ready", {31'd0, pix_ready}, 32'd1);
    for (int k = 0; k < 72; k++) begin
      pix_valid = 1'b1;
      pix_byte  = 8'(k);
      tick();
      if (k == 0) check("we_rise", {31'd0, write_en}, 32'd1);
      if (write_en) we_cnt++;
    end
    // write_en rises at the first accept edge and falls at the 72nd accept edge
    check("we_high_edges", we_cnt, 32'd71);
    check("load_we_low",    {31'd0, write_en},   32'd0);
    check("load_pix_ready", {31'd0, pix_ready},  32'd0);
    check("load_busy",      {31'd0, frame_busy}, 32'd1);
    check("load_pd1",       {24'd0, pixel_data1}, 32'h00);
    check("load_pd2",       {24'd0, pixel_data2}, 32'h01);
    tick();
    pix_valid = 1'b0;
    check("run_ignores_host", {24'd0, pixel_data1}, 32'h00);

    // Rotation wrap
    shift_network = 1'b1;
    repeat (71) tick();
    shift_network = 1'b0;
    check("wrap71_pd1", {24'd0, pixel_data1}, 32'h47);
    check("wrap71_pd2", {24'd0, pixel_data2}, 32'h00);
    shift_network = 1'b1;
    tick();
    shift_network = 1'b0;
    check("wrap72_pd1", {24'd0, pixel_data1}, 32'h00);
    check("wrap72_pd2", {24'd0, pixel_data2}, 32'h01);

    // Done vs shift collision at rd_ptr=5
    shift_network = 1'b1;
    repeat (5) tick();
    shift_network = 1'b0;
    check("rd5_pd1", {24'd0, pixel_data1}, 32'h05);
    check("rd5_pd2", {24'd0, pixel_data2}, 32'h06);
    shift_network = 1'b1; network_done = 1'b1;
    tick();
    shift_network = 1'b0; network_done = 1'b0;
    check("coll_busy",      {31'd0, frame_busy}, 32'd0);
    check("coll_pd1",       {24'd0, pixel_data1}, 32'h00);
    check("coll_pd2",       {24'd0, pixel_data2}, 32'h01);
    check("coll_pix_ready", {31'd0, pix_ready},  32'd1);
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
    check("coll_rot_err", {31'd0, rot_err}, 32'd1);
    tick();
    check("coll_rot_err_hold", {31'd0, rot_err}, 32'd1);
`endif

    // Following frame with host gaps, then walk the whole buffer
    load_frame(8'h80, 5);
    check("gap_we_low", {31'd0, write_en},   32'd0);
    check("gap_busy",   {31'd0, frame_busy}, 32'd1);
    for (int i = 0; i < 72; i++) begin
      check("order_pd1", {24'd0, pixel_data1}, 32'(8'h80 + 8'(i)));
      shift_network = 1'b1;
      tick();
      shift_network = 1'b0;
    end
    check("order_back_pd1", {24'd0, pixel_data1}, 32'h80);
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    check("done_busy", {31'd0, frame_busy}, 32'd0);
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
    check("done72_rot_err", {31'd0, rot_err}, 32'd0);
`endif

    // Shift/done in IDLE are ignored
    shift_network = 1'b1; network_done = 1'b1;
    tick();
    shift_network = 1'b0; network_done = 1'b0;
    check("idle_ign_busy", {31'd0, frame_busy}, 32'd0);
    check("idle_ign_pd2",  {24'd0, pixel_data2}, 32'h81);

    // Reset mid-load after 30 bytes
    for (int k = 0; k < 30; k++) begin
      pix_valid = 1'b1;
      pix_byte  = 8'(8'h10 + 8'(k));
      tick();
    end
    pix_valid = 1'b0;
    check("mid_we", {31'd0, write_en}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_we",        {31'd0, write_en},   32'd0);
    check("mrst_busy",      {31'd0, frame_busy}, 32'd0);
    check("mrst_pd1",       {24'd0, pixel_data1}, 32'h00);
    check("mrst_pd2",       {24'd0, pixel_data2}, 32'h00);
    check("mrst_pix_ready", {31'd0, pix_ready},  32'd1);

    // Full reload with shift/done held high (ignored in IDLE/LOAD)
    shift_network = 1'b1; network_done = 1'b1;
    load_frame(8'hB0, 0);
    shift_network = 1'b0; network_done = 1'b0;
    check("reload_pd1",   {24'd0, pixel_data1}, 32'hB0);
    check("reload_pd2",   {24'd0, pixel_data2}, 32'hB1);
    check("reload_we",    {31'd0, write_en},   32'd0);
    check("reload_busy",  {31'd0, frame_busy}, 32'd1);
    check("reload_ready", {31'd0, pix_ready},  32'd0);

    // 70 shifts then done: window not back at entry 0
    shift_network = 1'b1;
    repeat (70) tick();
    shift_network = 1'b0;
    check("sh70_pd1", {24'd0, pixel_data1}, 32'hF6);
    check("sh70_pd2", {24'd0, pixel_data2}, 32'hF7);
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    check("sh70_busy", {31'd0, frame_busy}, 32'd0);
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
    check("sh70_rot_err", {31'd0, rot_err}, 32'd1);
    repeat (3) tick();
    check("sh70_rot_err_hold", {31'd0, rot_err}, 32'd1);
`endif

    // New frame, 144 shifts then done
    load_frame(8'h00, 0);
    shift_network = 1'b1;
    repeat (144) tick();
    shift_network = 1'b0;
    check("sh144_pd1", {24'd0, pixel_data1}, 32'h00);
    check("sh144_pd2", {24'd0, pixel_data2}, 32'h01);
    network_done = 1'b1;
    tick();
    network_done = 1'b0;
    check("sh144_busy", {31'd0, frame_busy}, 32'd0);
`ifdef PIXEL_FRAME_BUFFER_ROTCHK_EN
    check("sh144_rot_err", {31'd0, rot_err}, 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
